// File: rtl/simd_arb.sv
// Round-robin arbiter that shares one fixed-latency SIMD datapath among N requesters.
// Carries a {valid, id, err} tag alongside the datapath and returns registered responses.
module simd_arb #(
  parameter int unsigned N   = 4,
  parameter int unsigned LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req_vld,
  input  logic [4*N-1:0]         req_op,
  input  logic [32*N-1:0]        req_a,
  input  logic [32*N-1:0]        req_b,
  output logic [N-1:0]           req_rdy,
  output logic                   dp_vld,
  output logic [3:0]             dp_op,
  output logic [31:0]            dp_a,
  output logic [31:0]            dp_b,
  input  logic [31:0]            dp_w,
  output logic [N-1:0]           rsp_vld,
  output logic [31:0]            rsp_w,
  output logic                   rsp_err,
  output logic [$clog2(N)-1:0]   rsp_id
);

  localparam int unsigned IW = $clog2(N);

  // Arbitration
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] arb_id;
  logic [IW-1:0] gnt_id;
  logic          gnt_any;
  logic          gnt_vld;
  logic [N-1:0]  gnt;
  logic [3:0]    sel_op;
  logic [31:0]   sel_a;
  logic [31:0]   sel_b;

  always_comb begin
    arb_id  = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      arb_id = IW'((32'(ptr_q) + 32'd1 + k) % N);
      if (!gnt_any && req_vld[arb_id]) begin
        gnt_any = 1'b1;
        gnt_id  = arb_id;
      end
    end
    gnt_vld = gnt_any & ~rst;
    gnt     = '0;
    if (gnt_vld) gnt[gnt_id] = 1'b1;
  end

  assign req_rdy = gnt;
  assign sel_op  = req_op[4*gnt_id +: 4];
  assign sel_a   = req_a[32*gnt_id +: 32];
  assign sel_b   = req_b[32*gnt_id +: 32];
  assign ptr_d   = gnt_vld ? gnt_id : ptr_q;

  // Issue stage: legal ops go to the datapath, illegal ops only occupy the slot
  logic          iss_vld_q, iss_vld_d;
  logic [3:0]    iss_op_q, iss_op_d;
  logic [31:0]   iss_a_q, iss_a_d;
  logic [31:0]   iss_b_q, iss_b_d;
  logic          iss_tv_q, iss_tv_d;
  logic [IW-1:0] iss_tid_q, iss_tid_d;
  logic          iss_terr_q, iss_terr_d;

  always_comb begin
    iss_vld_d  = gnt_vld & ~sel_op[3];
    iss_op_d   = '0;
    iss_a_d    = '0;
    iss_b_d    = '0;
    iss_tv_d   = gnt_vld;
    iss_tid_d  = '0;
    iss_terr_d = gnt_vld & sel_op[3];
    if (iss_vld_d) begin
      iss_op_d = sel_op;
      iss_a_d  = sel_a;
      iss_b_d  = sel_b;
    end
    if (gnt_vld) iss_tid_d = gnt_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= IW'(N - 1);
      iss_vld_q  <= 1'b0;
      iss_op_q   <= '0;
      iss_a_q    <= '0;
      iss_b_q    <= '0;
      iss_tv_q   <= 1'b0;
      iss_tid_q  <= '0;
      iss_terr_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      iss_vld_q  <= iss_vld_d;
      iss_op_q   <= iss_op_d;
      iss_a_q    <= iss_a_d;
      iss_b_q    <= iss_b_d;
      iss_tv_q   <= iss_tv_d;
      iss_tid_q  <= iss_tid_d;
      iss_terr_q <= iss_terr_d;
    end
  end

  // Tag pipeline: stage LAT-1 lines up with the cycle dp_w is valid
  logic          pipe_vld_q [LAT];
  logic [IW-1:0] pipe_id_q  [LAT];
  logic          pipe_err_q [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned j = 0; j < LAT; j++) begin
        pipe_vld_q[j] <= 1'b0;
        pipe_id_q[j]  <= '0;
        pipe_err_q[j] <= 1'b0;
      end
    end else begin
      pipe_vld_q[0] <= iss_tv_q;
      pipe_id_q[0]  <= iss_tid_q;
      pipe_err_q[0] <= iss_terr_q;
      for (int unsigned j = 1; j < LAT; j++) begin
        pipe_vld_q[j] <= pipe_vld_q[j-1];
        pipe_id_q[j]  <= pipe_id_q[j-1];
        pipe_err_q[j] <= pipe_err_q[j-1];
      end
    end
  end

  // Response stage
  logic [N-1:0]  rsp_vld_q, rsp_vld_d;
  logic [31:0]   rsp_w_q, rsp_w_d;
  logic          rsp_err_q, rsp_err_d;
  logic [IW-1:0] rsp_id_q, rsp_id_d;
  logic          tail_vld;
  logic [IW-1:0] tail_id;
  logic          tail_err;

  assign tail_vld = pipe_vld_q[LAT-1];
  assign tail_id  = pipe_id_q[LAT-1];
  assign tail_err = pipe_err_q[LAT-1];

  always_comb begin
    rsp_vld_d = '0;
    rsp_w_d   = '0;
    rsp_err_d = 1'b0;
    rsp_id_d  = '0;
    if (tail_vld) begin
      rsp_vld_d[tail_id] = 1'b1;
      rsp_id_d           = tail_id;
      rsp_err_d          = tail_err;
      rsp_w_d            = tail_err ? 32'd0 : dp_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld_q <= '0;
      rsp_w_q   <= '0;
      rsp_err_q <= 1'b0;
      rsp_id_q  <= '0;
    end else begin
      rsp_vld_q <= rsp_vld_d;
      rsp_w_q   <= rsp_w_d;
      rsp_err_q <= rsp_err_d;
      rsp_id_q  <= rsp_id_d;
    end
  end

  // Registers only clear at the edge, so mask outputs for the reset cycle itself
  assign dp_vld  = iss_vld_q & ~rst;
  assign dp_op   = rst ? 4'd0  : iss_op_q;
  assign dp_a    = rst ? 32'd0 : iss_a_q;
  assign dp_b    = rst ? 32'd0 : iss_b_q;
  assign rsp_vld = rst ? '0    : rsp_vld_q;
  assign rsp_w   = rst ? 32'd0 : rsp_w_q;
  assign rsp_err = rsp_err_q & ~rst;
  assign rsp_id  = rst ? '0    : rsp_id_q;

  a_rdy_onehot : assert property (@(posedge clk) $onehot0(req_rdy));
  a_rdy_needs_vld : assert property (@(posedge clk) (req_rdy & ~req_vld) == '0);

endmodule

// File: tb/tb_simd_arb.sv
// Table-driven bench for simd_arb with a behavioural datapath and a response scoreboard.
module tb_simd_arb;

  localparam int unsigned N   = 4;
  localparam int unsigned LAT = 2;
  localparam logic [3:0] OpAdd32 = 4'b0010;
  localparam logic [3:0] OpSub8  = 4'b0011;
  localparam logic [3:0] OpBad   = 4'b1010;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_vld;
  logic [4*N-1:0]  req_op;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [N-1:0]    req_rdy;
  logic            dp_vld;
  logic [3:0]      dp_op;
  logic [31:0]     dp_a;
  logic [31:0]     dp_b;
  logic [31:0]     dp_w;
  logic [N-1:0]    rsp_vld;
  logic [31:0]     rsp_w;
  logic            rsp_err;
  logic [1:0]      rsp_id;

  simd_arb #(.N(N), .LAT(LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_vld (req_vld),
    .req_op  (req_op),
    .req_a   (req_a),
    .req_b   (req_b),
    .req_rdy (req_rdy),
    .dp_vld  (dp_vld),
    .dp_op   (dp_op),
    .dp_a    (dp_a),
    .dp_b    (dp_b),
    .dp_w    (dp_w),
    .rsp_vld (rsp_vld),
    .rsp_w   (rsp_w),
    .rsp_err (rsp_err),
    .rsp_id  (rsp_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  logic check_en = 1'b0;

  function automatic logic [31:0] dp_fn(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    if (op == OpAdd32) r = a + b;
    else if (op == OpSub8) begin
      for (int k = 0; k < 4; k++) r[8*k +: 8] = a[8*k +: 8] - b[8*k +: 8];
    end else r = a ^ b;
    return r;
  endfunction

  // Behavioural datapath: result appears LAT cycles after the dp_vld cycle
  logic        m_vld [LAT];
  logic [3:0]  m_op  [LAT];
  logic [31:0] m_a   [LAT];
  logic [31:0] m_b   [LAT];

  always @(posedge clk) begin
    m_vld[0] <= (dp_vld === 1'b1);
    m_op[0]  <= dp_op;
    m_a[0]   <= dp_a;
    m_b[0]   <= dp_b;
    for (int j = 1; j < LAT; j++) begin
      m_vld[j] <= m_vld[j-1];
      m_op[j]  <= m_op[j-1];
      m_a[j]   <= m_a[j-1];
      m_b[j]   <= m_b[j-1];
    end
  end

  assign dp_w = (m_vld[LAT-1] === 1'b1) ? dp_fn(m_op[LAT-1], m_a[LAT-1], m_b[LAT-1])
                                        : 32'hDEAD_BEEF;

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic [3:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0] exp_rdy;
  } vec_t;

  typedef struct {
    int          due;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } iss_t;

  typedef struct {
    int          due;
    logic [1:0]  id;
    logic        err;
    logic [31:0] w;
  } rsp_t;

  vec_t tbl[$];
  iss_t iss_q[$];
  rsp_t rsp_q[$];

  function automatic vec_t mk(logic r, logic [3:0] v, logic [3:0] op, logic [31:0] a,
                              logic [31:0] b, logic [3:0] er);
    vec_t t;
    t.rst = r; t.vld = v; t.op = op; t.a = a; t.b = b; t.exp_rdy = er;
    return t;
  endfunction

  function automatic logic [31:0] opa(vec_t r, int i);
    return r.a + 32'(i) * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] opb(vec_t r, int i);
    return r.b ^ 32'(i);
  endfunction

  task automatic idle(int n);
    for (int k = 0; k < n; k++) tbl.push_back(mk(1'b0, 4'b0000, 4'd0, 32'd0, 32'd0, 4'b0000));
  endtask

  task automatic apply(vec_t r);
    int gi;
    @(posedge clk);
    #1;
    rst     = r.rst;
    req_vld = r.vld;
    for (int i = 0; i < N; i++) begin
      req_op[4*i +: 4]   = r.op;
      req_a[32*i +: 32]  = opa(r, i);
      req_b[32*i +: 32]  = opb(r, i);
    end
    if (r.rst) begin
      iss_q.delete();
      rsp_q.delete();
    end else if (r.exp_rdy != 4'b0000) begin
      iss_t ie;
      rsp_t re;
      gi = 0;
      for (int i = 0; i < N; i++) if (r.exp_rdy[i]) gi = i;
      if (!r.op[3]) begin
        ie.due = cyc + 1; ie.op = r.op; ie.a = opa(r, gi); ie.b = opb(r, gi);
        iss_q.push_back(ie);
      end
      re.due = cyc + 2 + LAT;
      re.id  = 2'(gi);
      re.err = r.op[3];
      re.w   = r.op[3] ? 32'd0 : dp_fn(r.op, opa(r, gi), opb(r, gi));
      rsp_q.push_back(re);
    end
    @(negedge clk);
    vectors++;
    if (req_rdy !== r.exp_rdy) begin
      miscompares++;
      $display("FAIL req_rdy cyc=%0d got=%b want=%b", cyc, req_rdy, r.exp_rdy);
    end
  endtask

  // Scoreboard: datapath issue and response checked every cycle
  always @(negedge clk) begin
    if (check_en) begin
      logic        e_dv;
      logic [3:0]  e_op;
      logic [31:0] e_a, e_b, e_w;
      logic [3:0]  e_rv;
      logic [1:0]  e_id;
      logic        e_err;
      e_dv = 1'b0; e_op = '0; e_a = '0; e_b = '0;
      e_rv = '0; e_id = '0; e_err = 1'b0; e_w = '0;
      if (iss_q.size() > 0 && iss_q[0].due == cyc) begin
        e_dv = 1'b1; e_op = iss_q[0].op; e_a = iss_q[0].a; e_b = iss_q[0].b;
        void'(iss_q.pop_front());
      end
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
        e_rv = 4'b0001 << rsp_q[0].id; e_id = rsp_q[0].id;
        e_err = rsp_q[0].err; e_w = rsp_q[0].w;
        void'(rsp_q.pop_front());
      end
      vectors++;
      if ({dp_vld, dp_op, dp_a, dp_b} !== {e_dv, e_op, e_a, e_b}) begin
        miscompares++;
        $display("FAIL issue cyc=%0d got=%b/%h/%h/%h want=%b/%h/%h/%h", cyc,
                 dp_vld, dp_op, dp_a, dp_b, e_dv, e_op, e_a, e_b);
      end
      vectors++;
      if ({rsp_vld, rsp_id, rsp_err, rsp_w} !== {e_rv, e_id, e_err, e_w}) begin
        miscompares++;
        $display("FAIL response cyc=%0d got=%b/%0d/%b/%h want=%b/%0d/%b/%h", cyc,
                 rsp_vld, rsp_id, rsp_err, rsp_w, e_rv, e_id, e_err, e_w);
      end
      if (rst) begin
        vectors++;
        if (req_rdy !== 4'b0000) begin
          miscompares++;
          $display("FAIL rdy_in_reset cyc=%0d got=%b want=0000", cyc, req_rdy);
        end
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1; req_vld = '0; req_op = '0; req_a = '0; req_b = '0;

    // Round-robin from reset, all requesters busy
    for (int k = 0; k < 6; k++)
      tbl.push_back(mk(1'b0, 4'b1111, OpAdd32, 32'h1000_0000 + 32'(k), 32'h0000_0100,
                       4'b0001 << (k % 4)));
    idle(5);
    // Single legal op with carry-out wrap
    tbl.push_back(mk(1'b0, 4'b0001, OpAdd32, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0001));
    idle(4);
    // Illegal op from requester 2
    tbl.push_back(mk(1'b0, 4'b0100, OpBad, 32'h1234_5678, 32'h9ABC_DEF0, 4'b0100));
    idle(4);
    // Back-to-back SUB8 from requester 1
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1'b0, 4'b0010, OpSub8, 32'h8070_6050 + 32'(k) * 32'h0102_0304,
                       32'h0910_2030 + 32'(k) * 32'h0301_0203, 4'b0010));
    // Rotation after requester 1: 2 before 0
    tbl.push_back(mk(1'b0, 4'b0101, OpAdd32, 32'h0000_00AA, 32'h0000_0011, 4'b0100));
    tbl.push_back(mk(1'b0, 4'b0101, OpAdd32, 32'h0000_00BB, 32'h0000_0022, 4'b0001));
    idle(5);
    // Reset mid-flight, then priority restarts at requester 0
    tbl.push_back(mk(1'b0, 4'b0001, OpAdd32, 32'h5555_0000, 32'h0000_AAAA, 4'b0001));
    idle(1);
    tbl.push_back(mk(1'b1, 4'b1111, OpAdd32, 32'h0, 32'h0, 4'b0000));
    idle(6);
    tbl.push_back(mk(1'b0, 4'b1001, OpSub8, 32'h4433_2211, 32'h0102_0304, 4'b0001));
    tbl.push_back(mk(1'b0, 4'b1001, OpSub8, 32'h4433_2211, 32'h0102_0304, 4'b1000));
    idle(6);

    repeat (2) @(posedge clk);
    #1;
    check_en = 1'b1;
    @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    guard = 0;
    while ((iss_q.size() > 0 || rsp_q.size() > 0) && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    vectors++;
    if (iss_q.size() > 0 || rsp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain got=%0d/%0d pending want=0/0", iss_q.size(), rsp_q.size());
    end
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
